td4_input_port: RTL and testbench

Input-side companion to the TD4 CPU's 4-bit LED output path. Takes raw, asynchronous board switches/buttons, synchronizes and debounces them on the fast board clock, and presents a value on `in_` that changes only at CPU clock ticks. Optional sticky capture records short presses between ticks. Sits between the board pins and the TD4 `in_` port, beside the clock divider, replacing the constant-zero input tie-off.

---
 rtl/td4_input_port.sv | 101 ++++++++++
 tb/tb_td4_input_port.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/td4_input_port.sv
// td4_input_port: synchronizes and debounces raw board switches and presents
// them to the TD4 CPU as a value that only changes on CPU clock ticks.
module td4_input_port #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 16,
  parameter int STICKY   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             tick,
  output logic [WIDTH-1:0] in_,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0]         s1_q;
  logic [WIDTH-1:0]         s2_q;
  logic [WIDTH-1:0]         level_q;
  logic [WIDTH-1:0]         level_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  logic [WIDTH-1:0]         press_q;
  logic [WIDTH-1:0]         press_d;
  logic [WIDTH-1:0]         in_q;
  logic [WIDTH-1:0]         in_d;
  logic                     changed_q;
  logic                     changed_d;
  logic [WIDTH-1:0]         rise_s;

  // Per-bit debounce: reaching CNT_MAX either transfers the bit or the count
  // restarts, so the counter can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge detect and tick sampling; a rise landing on a tick edge is parked in
  // press so the following tick still reports it.
  always_comb begin
    rise_s    = level_d & ~level_q;
    changed_d = |(level_d ^ level_q);
    in_d      = in_q;
    press_d   = '0;
    if (STICKY != 0) begin
      if (tick) begin
        in_d    = level_q | press_q;
        press_d = rise_s;
      end else begin
        in_d    = in_q;
        press_d = press_q | rise_s;
      end
    end else begin
      if (tick) begin
        in_d = level_q;
      end else begin
        in_d = in_q;
      end
      press_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      in_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= sw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      in_q      <= in_d;
      changed_q <= changed_d;
    end
  end

  assign in_     = in_q;
  assign level   = level_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_td4_input_port.sv
// Directed bench for td4_input_port: a sticky and a non-sticky instance with
// DEBOUNCE=4 share the same stimulus.
module tb_td4_input_port;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw = 4'hF;
  logic         tick = 1'b0;
  logic [W-1:0] in_s, level_s, in_n, level_n;
  logic         changed_s, changed_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  td4_input_port #(.WIDTH(W), .DEBOUNCE(4), .STICKY(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .sw(sw), .tick(tick),
    .in_(in_s), .level(level_s), .changed(changed_s)
  );

  td4_input_port #(.WIDTH(W), .DEBOUNCE(4), .STICKY(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .sw(sw), .tick(tick),
    .in_(in_n), .level(level_n), .changed(changed_n)
  );

  typedef struct {
    logic [3:0] sw;
    logic       tick;
    logic [3:0] lvl;
    logic       chg;
    logic [3:0] in_s;
    logic [3:0] in_n;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1ns after the rising edge.
  task automatic cyc(input logic [W-1:0] s, input logic t);
    sw   = s;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean press on bit 0; row k shows state after edge k+1.
    tbl[0]  = '{4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[4]  = '{4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[5]  = '{4'h1, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0};
    tbl[6]  = '{4'h1, 1'b0, 4'h1, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[8]  = '{4'h0, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[9]  = '{4'h0, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[10] = '{4'h0, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[11] = '{4'h0, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[12] = '{4'h0, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b1, 4'h1, 4'h1};
    tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0};

    // Reset held with switches high and tick toggling
    for (int k = 0; k < 6; k++) begin
      cyc(4'hF, k[0]);
      chk("rst.in_s", in_s, 4'h0);
      chk("rst.level", level_s, 4'h0);
      chk("rst.changed", changed_s, 1'b0);
      chk("rst.in_n", in_n, 4'h0);
    end
    sw      = 4'h0;
    reset_n = 1'b1;
    repeat (3) cyc(4'h0, 1'b0);
    chk("idle.level", level_s, 4'h0);

    for (int k = 0; k < 15; k++) begin
      cyc(tbl[k].sw, tbl[k].tick);
      chk($sformatf("press[%0d].level_s", k), level_s, tbl[k].lvl);
      chk($sformatf("press[%0d].level_n", k), level_n, tbl[k].lvl);
      chk($sformatf("press[%0d].changed", k), changed_s, tbl[k].chg);
      chk($sformatf("press[%0d].in_s", k), in_s, tbl[k].in_s);
      chk($sformatf("press[%0d].in_n", k), in_n, tbl[k].in_n);
    end

    // Bounce on bit 2 with 3-cycle runs never reaches level
    for (int k = 0; k < 42; k++) begin
      cyc((((k / 3) % 2) == 0) ? 4'h4 : 4'h0, 1'b0);
      chk($sformatf("bounce[%0d].level", k), level_s, 4'h0);
      chk($sformatf("bounce[%0d].changed", k), changed_s, 1'b0);
    end
    repeat (5) cyc(4'h4, 1'b0);
    chk("bounce.hold5.level", level_s, 4'h0);
    cyc(4'h4, 1'b0);
    chk("bounce.hold6.level", level_s, 4'h4);
    chk("bounce.hold6.changed", changed_s, 1'b1);
    repeat (8) cyc(4'h0, 1'b0);
    chk("bounce.release.level", level_s, 4'h0);
    // Press from the bounce rise survives to the tick; back-to-back tick clears
    cyc(4'h0, 1'b1);
    chk("b2b.tick1.in_s", in_s, 4'h4);
    chk("b2b.tick1.in_n", in_n, 4'h0);
    cyc(4'h0, 1'b1);
    chk("b2b.tick2.in_s", in_s, 4'h0);

    // Short press on bit 1 between ticks 50 cycles apart
    for (int k = 1; k <= 100; k++) begin
      cyc(((k >= 11) && (k <= 20)) ? 4'h2 : 4'h0, ((k == 50) || (k == 100)) ? 1'b1 : 1'b0);
      if (k == 18) chk("short.level_mid", level_s, 4'h2);
      if (k == 20) chk("short.in_hold", in_s, 4'h0);
      if (k == 30) chk("short.level_after", level_s, 4'h0);
      if (k == 50) begin
        chk("short.tick1.in_s", in_s, 4'h2);
        chk("short.tick1.in_n", in_n, 4'h0);
      end
      if (k == 100) begin
        chk("short.tick2.in_s", in_s, 4'h0);
        chk("short.tick2.in_n", in_n, 4'h0);
      end
    end

    // Bit 3 rises on the same edge as a tick, released before the next tick
    for (int k = 1; k <= 21; k++) begin
      cyc((k <= 6) ? 4'h8 : 4'h0, ((k == 6) || (k == 20) || (k == 21)) ? 1'b1 : 1'b0);
      if (k == 6) begin
        chk("coinc.level", level_s, 4'h8);
        chk("coinc.tick1.in_s", in_s, 4'h0);
        chk("coinc.tick1.in_n", in_n, 4'h0);
      end
      if (k == 19) chk("coinc.level_fall", level_s, 4'h0);
      if (k == 20) begin
        chk("coinc.tick2.in_s", in_s, 4'h8);
        chk("coinc.tick2.in_n", in_n, 4'h0);
      end
      if (k == 21) chk("coinc.tick3.in_s", in_s, 4'h0);
    end

    // Reset pulse mid-debounce discards the partial count
    repeat (5) cyc(4'h1, 1'b0);
    chk("midrst.before.level", level_s, 4'h0);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    cyc(4'h1, 1'b0);
    chk("midrst.edge1.level", level_s, 4'h0);
    repeat (4) cyc(4'h1, 1'b0);
    chk("midrst.edge5.level", level_s, 4'h0);
    cyc(4'h1, 1'b0);
    chk("midrst.edge6.level", level_s, 4'h1);

    // Asynchronous reset clears outputs before the next edge
    repeat (7) cyc(4'hF, 1'b0);
    cyc(4'hF, 1'b1);
    chk("async.pre.level", level_s, 4'hF);
    chk("async.pre.in_s", in_s, 4'hF);
    chk("async.pre.in_n", in_n, 4'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("async.level", level_s, 4'h0);
    chk("async.in_s", in_s, 4'h0);
    chk("async.in_n", in_n, 4'h0);
    chk("async.changed", changed_s, 1'b0);
    #2 reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
